aes_inv_cipher_seq: RTL

Iterative AES inverse cipher (FIPS-197 InvCipher) that takes one 128-bit ciphertext block per transaction and computes one inverse round per clock. It supports AES-128/192/256, selected by the same two-bit key-size encoding as the board switches (set1,set2). The block sits on the decrypt side of the AES datapath. It consumes the pre-expanded schedule produced by KeyExpantion, and its plaintext output feeds the compare/seven-segment display logic. It replaces the free-running combinational Decipher with a handshaked, sequenced engine.

---
 rtl/aes_inv_cipher_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/aes_inv_cipher_seq.sv
// Iterative AES-128/192/256 inverse cipher, one inverse round per clock.
// Consumes a pre-expanded, right-justified key schedule held stable by the
// source for the duration of a block; plaintext leaves on a valid/ready port.
module aes_inv_cipher_seq (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    key_sel,
  input  logic [1919:0] w,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic          busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Inverse S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  logic [1:0]   state_q, state_d;
  logic [3:0]   nr_q, nr_d;
  logic [3:0]   round_cnt_q, round_cnt_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] out_data_q, out_data_d;
  logic [3:0]   rk_sel;
  logic [10:0]  rk_base;
  logic [127:0] rk;
  logic [127:0] round_out;

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return INV_SBOX[idx +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r is rotated right by r byte positions.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Coefficients 0e/0b/0d/09 built from the x2, x4, x8 xtime chain.
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   x2 [4];
    logic [7:0]   x4 [4];
    logic [7:0]   x8 [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        a[i]  = s[127-8*(i+4*c) -: 8];
        x2[i] = xtime(a[i]);
        x4[i] = xtime(x2[i]);
        x8[i] = xtime(x4[i]);
      end
      for (int i = 0; i < 4; i++)
        o[127-8*(i+4*c) -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                              ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                              ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                              ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
    end
    return o;
  endfunction

  // Round key r sits (Nr - r) 128-bit words above the bottom of the schedule,
  // so rk[Nr] is always w[127:0].
  assign rk_sel  = nr_q - round_cnt_q;
  assign rk_base = {rk_sel, 7'b0000000};
  assign rk      = w[rk_base +: 128];

  assign in_ready  = (state_q == S_IDLE) && (key_sel != 2'b11);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;

  // One inverse round; the final round skips InvMixColumns.
  always_comb begin
    logic [127:0] t;
    t = inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk;
    round_out = (round_cnt_q != 4'd0) ? inv_mix_columns(t) : t;
  end

  // Sequencing: accept, iterate rounds, hold result until taken.
  always_comb begin
    state_d     = state_q;
    nr_d        = nr_q;
    round_cnt_d = round_cnt_q;
    blk_d       = blk_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          case (key_sel)
            2'b00:   nr_d = 4'd10;
            2'b01:   nr_d = 4'd12;
            default: nr_d = 4'd14;
          endcase
          blk_d       = in_data ^ w[127:0];
          round_cnt_d = nr_d - 4'd1;
          state_d     = S_ROUND;
        end
      end
      S_ROUND: begin
        blk_d = round_out;
        if (round_cnt_q == 4'd0) begin
          out_data_d = round_out;
          state_d    = S_DONE;
        end else begin
          round_cnt_d = round_cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset clears everything so no partial result escapes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      nr_q        <= 4'd0;
      round_cnt_q <= 4'd0;
      blk_q       <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      nr_q        <= nr_d;
      round_cnt_q <= round_cnt_d;
      blk_q       <= blk_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule
